lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Two-client arbiter that shares one `lifo` instance between two requesters. It issues at most one push or pop to the LIFO per cycle and grants clients round-robin. It tracks occupancy locally to provide `empty`, which the LIFO does not export. Pop results are routed back to the client that issued the pop. It sits between the `lifo` instance and its two users.

## Interface
- `DATA_W`, 10, data width; matches the LIFO word.
- `DEPTH`, 8, LIFO capacity in words.
- `CNT_W`, 4, occupancy counter width; must satisfy 2^CNT_W > DEPTH.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_push`, `req1_push`  in  1  client n requests a push.
- `req0_pop`, `req1_pop`  in  1  client n requests a pop.
- `req0_data`, `req1_data`  in  DATA_W  push data for client n.
- `gnt0`, `gnt1`  out  1  request of client n accepted this cycle.
- `rsp0_valid`, `rsp1_valid`  out  1  pop result for client n is valid.
- `rsp0_data`, `rsp1_data`  out  DATA_W  pop result.
- `lifo_write`  out  1  to LIFO `write`.
- `lifo_datain`  out  DATA_W  to LIFO `datain`.
- `lifo_read`  out  1  to LIFO `read`.
- `lifo_dataout`  in  DATA_W  from LIFO `dataout`.
- `lifo_val`  in  1  from LIFO `val`.
- `lifo_full`  in  1  from LIFO `full`.
- `count`  out  CNT_W  current occupancy.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH` or `lifo_full`.

## Operation
**Request rules**
- A client holds its request and data stable until it sees its grant.
- If a client asserts push and pop together, the pop wins and the push is not granted.

**Eligibility**
- A push is eligible when `full` is 0.
- A pop is eligible when `empty` is 0.
- Ineligible requests are held off, never dropped.

**State machine**
- IDLE:
  - If exactly one client has an eligible request, that client is granted.
  - If both do, the round-robin pointer `rr` picks the winner.
  - After any grant, `rr` points to the other client.
  - A pop grant moves to WAIT_RSP and records `owner`.
  - A push grant stays in IDLE.
- WAIT_RSP:
  - No grants are issued.
  - On `lifo_val` = 1, the owner's `rsp_valid` is 1 for that cycle and the state returns to IDLE.

**Datapath and counting**
- A granted push drives `lifo_write` = 1 with `lifo_datain` = the winner's data.
- A granted pop drives `lifo_read` = 1.
- `lifo_write` and `lifo_read` are never both 1.
- `count` increments on a push grant and decrements on a pop grant, at the granting edge. It never wraps.
- Non-owner `rsp_valid` is always 0.
- `rsp_data` = `lifo_dataout` on both clients; only the qualified one is valid.

**Reset**
- The LIFO shares the same reset event, so `count` = 0 is consistent with it.
- Reset in WAIT_RSP drops the pending response.

## Timing
- Reset values:
  - `gnt*` = 0, `rsp*_valid` = 0.
  - `lifo_write` = 0, `lifo_read` = 0.
  - `count` = 0, `empty` = 1, `full` = 0 (unless `lifo_full` is 1).
  - State = IDLE, `rr` = client 0, `owner` = 0.
- `gnt*`, `lifo_write`, `lifo_read` and `lifo_datain` are combinational from the requests, state, `rr` and `count`. They are valid in the same cycle as the request.
- `count`, state, `rr` and `owner` update on the rising edge.
- `rsp*_valid` and `rsp*_data` are combinational pass-through of `lifo_val` and `lifo_dataout`, qualified by `owner` and WAIT_RSP.
- Throughput:
  - Pushes: one per cycle.
  - Pops: one per (1 + LIFO response latency) cycles.
- Boundaries:
  - At `count == DEPTH`, push requests see `gnt` = 0 until a pop completes.
  - At `count == 0`, pop requests see `gnt` = 0.
  - When one client pushes and the other pops with both eligible, only the `rr` winner proceeds that cycle.
- `lifo_val` in IDLE is ignored.

## Configuration
- `LIFO_ARB_FIXED_PRI_EN`
  - Defined: client 0 always wins a contested cycle and `rr` is unused (held at 0).
  - Undefined (default): round-robin as described.

## Test plan
- Reset:
  - Stimulus: assert `reset` = 0 while client 0 holds a pop in WAIT_RSP.
  - Required: all outputs at reset values, state = IDLE, no `rsp0_valid`.
- Fill:
  - Stimulus: client 0 pushes 0x001…0x008, one per cycle.
  - Required: `gnt0` = 1 for 8 cycles, `count` = 8, `full` = 1.
  - Stimulus: a 9th push.
  - Required: `gnt0` = 0 with `count` holding at 8.
- Empty pop:
  - Stimulus: client 1 pops at `count` = 0.
  - Required: `gnt1` = 0 and `lifo_read` = 0 indefinitely.
  - Stimulus: client 0 pushes 0x16B.
  - Required: the push is granted, then `gnt1` = 1, and `rsp1_valid` = 1 with data 0x16B; `rsp0_valid` stays 0.
- Contention:
  - Stimulus: both clients push continuously, starting after reset.
  - Required: grants alternate 0,1,0,1; `lifo_datain` alternates accordingly.
  - With `LIFO_ARB_FIXED_PRI_EN` defined: `gnt0` = 1 every cycle and `gnt1` = 0 until `full` = 1.
- Mixed:
  - Stimulus: with `count` = 3, client 0 pushes and client 1 pops in the same cycle with `rr` = 1.
  - Required: pop granted first, `count` = 2, state WAIT_RSP; the push is granted the cycle after the response, `count` = 3.
- Push+pop:
  - Stimulus: client 0 asserts both push and pop at `count` = 2.
  - Required: only `lifo_read` = 1; `count` becomes 1.

Source files
------------

// File: rtl/lifo_arbiter.sv
// ---------------------------------------------------------------------------
// lifo_arbiter
//
// Shares one LIFO instance between two clients. At most one push or pop is
// issued to the LIFO per cycle. Contested cycles are settled round-robin.
// Occupancy is tracked locally so that an `empty` flag exists; the LIFO
// itself exports only `full`. A pop result is steered back to the client
// that issued that pop.
//
// Optional build macro:
//   LIFO_ARB_FIXED_PRI_EN - client 0 always wins a contested cycle and the
//                           round-robin pointer is held at 0.
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous reset, active low
//   req{0,1}_push/_pop      client push / pop request (pop wins if both)
//   req{0,1}_data           client push data
//   gnt{0,1}                client request accepted this cycle
//   rsp{0,1}_valid/_data    pop result for the issuing client
//   lifo_write/_datain      push command and data to the LIFO
//   lifo_read               pop command to the LIFO
//   lifo_dataout/_val       pop result and its strobe from the LIFO
//   lifo_full               full flag from the LIFO
//   count, empty, full      local occupancy and status flags
// ---------------------------------------------------------------------------
module lifo_arbiter #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_push,
  input  logic              req0_pop,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_push,
  input  logic              req1_pop,
  input  logic [DATA_W-1:0] req1_data,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              lifo_write,
  output logic [DATA_W-1:0] lifo_datain,
  output logic              lifo_read,
  input  logic [DATA_W-1:0] lifo_dataout,
  input  logic              lifo_val,
  input  logic              lifo_full,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic             rr, rr_nxt;
  logic             owner, owner_nxt;
  logic [CNT_W-1:0] count_nxt;

  logic             push0, push1;
  logic             elig0, elig1;
  logic             grant_any;
  logic             win;
  logic             win_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX) || lifo_full;

  // A simultaneous push+pop from one client is treated as a pop only.
  assign push0 = req0_push && !req0_pop;
  assign push1 = req1_push && !req1_pop;

  // Ineligible requests simply see no grant; the client keeps holding them.
  assign elig0 = (req0_pop && !empty) || (push0 && !full);
  assign elig1 = (req1_pop && !empty) || (push1 && !full);

  // Winner selection, LIFO command generation and next-state logic.
  always_comb begin
    grant_any   = 1'b0;
    win         = 1'b0;
    win_pop     = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    lifo_write  = 1'b0;
    lifo_read   = 1'b0;
    lifo_datain = req0_data;
    state_nxt   = state;
    rr_nxt      = rr;
    owner_nxt   = owner;
    count_nxt   = count;

    case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          grant_any = 1'b1;
`ifdef LIFO_ARB_FIXED_PRI_EN
          win = 1'b0;
`else
          win = rr;
`endif
        end else if (elig0) begin
          grant_any = 1'b1;
          win       = 1'b0;
        end else if (elig1) begin
          grant_any = 1'b1;
          win       = 1'b1;
        end

        win_pop     = win ? req1_pop : req0_pop;
        lifo_datain = win ? req1_data : req0_data;

        if (grant_any) begin
          gnt0       = !win;
          gnt1       = win;
          lifo_read  = win_pop;
          lifo_write = !win_pop;
`ifdef LIFO_ARB_FIXED_PRI_EN
          rr_nxt = 1'b0;
`else
          rr_nxt = !win;
`endif
          if (win_pop) begin
            state_nxt = WAIT_RSP;
            owner_nxt = win;
            if (count != '0) count_nxt = count - CNT_ONE;
          end else begin
            if (count != CNT_MAX) count_nxt = count + CNT_ONE;
          end
        end
      end

      WAIT_RSP: begin
        if (lifo_val) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      owner <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end

  // Pop results are a pass-through; only the owner's strobe is qualified,
  // and a stray lifo_val outside WAIT_RSP is ignored.
  assign rsp0_valid = (state == WAIT_RSP) && lifo_val && !owner;
  assign rsp1_valid = (state == WAIT_RSP) && lifo_val && owner;
  assign rsp0_data  = lifo_dataout;
  assign rsp1_data  = lifo_dataout;

endmodule

// File: tb/tb_lifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lifo_arbiter
//
// Directed bench for lifo_arbiter. A small behavioural LIFO (one-cycle pop
// latency, shared reset) sits behind the arbiter. Each scenario task drives
// requests on the falling edge and checks outputs shortly afterwards.
// ---------------------------------------------------------------------------
module tb_lifo_arbiter;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              req0_push, req0_pop, req1_push, req1_pop;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              gnt0, gnt1;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic              lifo_write, lifo_read;
  logic [DATA_W-1:0] lifo_datain;
  logic [DATA_W-1:0] lifo_dataout;
  logic              lifo_val;
  logic              lifo_full;
  logic [CNT_W-1:0]  count;
  logic              empty, full;

  int total;
  int bad;

  lifo_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_push(req0_push), .req0_pop(req0_pop), .req0_data(req0_data),
    .req1_push(req1_push), .req1_pop(req1_pop), .req1_data(req1_data),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .lifo_write(lifo_write), .lifo_datain(lifo_datain), .lifo_read(lifo_read),
    .lifo_dataout(lifo_dataout), .lifo_val(lifo_val), .lifo_full(lifo_full),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural LIFO: pop result appears the cycle after lifo_read.
  logic [DATA_W-1:0] stk [DEPTH];
  logic [4:0]        sp;
  assign lifo_full = (sp == 5'(DEPTH));

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp           <= '0;
      lifo_val     <= 1'b0;
      lifo_dataout <= '0;
    end else begin
      lifo_val <= 1'b0;
      if (lifo_write && sp < 5'(DEPTH)) begin
        stk[sp[2:0]] <= lifo_datain;
        sp           <= sp + 5'd1;
      end else if (lifo_read && sp != 5'd0) begin
        lifo_dataout <= stk[sp[2:0] - 3'd1];
        lifo_val     <= 1'b1;
        sp           <= sp - 5'd1;
      end
    end
  end

  task automatic clear_reqs;
    req0_push = 1'b0; req0_pop = 1'b0; req0_data = '0;
    req1_push = 1'b0; req1_pop = 1'b0; req1_data = '0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b%b want 00", gnt0, gnt1); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp: got %b%b want 00", rsp0_valid, rsp1_valid); end
    total++; if (lifo_write !== 1'b0 || lifo_read !== 1'b0) begin bad++; $display("FAIL rst_cmd: got w=%b r=%b want 0 0", lifo_write, lifo_read); end
    total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_flags: got cnt=%0d e=%b f=%b want 0 1 0", count, empty, full); end
    @(negedge clk);
    reset = 1'b1;
    // Two pushes, then a pop that is cut short by reset in WAIT_RSP.
    req0_push = 1'b1; req0_data = 10'h055;
    @(negedge clk);
    req0_data = 10'h056;
    @(negedge clk);
    req0_push = 1'b0; req0_pop = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b1 || lifo_read !== 1'b1) begin bad++; $display("FAIL rst_popgnt: got g=%b r=%b want 1 1", gnt0, lifo_read); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_pop = 1'b0;
    #1;
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL rst_drop: got rsp0_valid=%b want 0", rsp0_valid); end
    total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL rst_wait_cnt: got cnt=%0d e=%b want 0 1", count, empty); end
    @(negedge clk);
    reset = 1'b1;
    req1_push = 1'b1; req1_data = 10'h077;
    #1;
    total++; if (gnt1 !== 1'b1 || lifo_write !== 1'b1) begin bad++; $display("FAIL rst_idle: got g1=%b w=%b want 1 1", gnt1, lifo_write); end
    @(negedge clk);
    req1_push = 1'b0;
  endtask

  task automatic test_fill;
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      req0_push = 1'b1; req0_data = DATA_W'(i);
      #1;
      total++; if (gnt0 !== 1'b1 || lifo_write !== 1'b1 || lifo_datain !== DATA_W'(i)) begin bad++; $display("FAIL fill_push%0d: got g=%b w=%b d=%h want 1 1 %h", i, gnt0, lifo_write, lifo_datain, DATA_W'(i)); end
      @(negedge clk);
    end
    req0_data = 10'h009;
    #1;
    total++; if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL fill_full: got cnt=%0d f=%b e=%b want 8 1 0", count, full, empty); end
    total++; if (gnt0 !== 1'b0 || lifo_write !== 1'b0) begin bad++; $display("FAIL fill_ninth: got g=%b w=%b want 0 0", gnt0, lifo_write); end
    @(negedge clk);
    #1;
    total++; if (count !== 4'd8 || gnt0 !== 1'b0) begin bad++; $display("FAIL fill_hold: got cnt=%0d g=%b want 8 0", count, gnt0); end
    req0_push = 1'b0;
    // Drain to confirm last-in-first-out order through client 0.
    for (int i = DEPTH; i >= 1; i--) begin
      req0_pop = 1'b1;
      #1;
      total++; if (gnt0 !== 1'b1 || lifo_read !== 1'b1) begin bad++; $display("FAIL drain_gnt%0d: got g=%b r=%b want 1 1", i, gnt0, lifo_read); end
      @(negedge clk);
      #1;
      total++; if (rsp0_valid !== 1'b1 || rsp0_data !== DATA_W'(i) || rsp1_valid !== 1'b0) begin bad++; $display("FAIL drain_rsp%0d: got v=%b d=%h v1=%b want 1 %h 0", i, rsp0_valid, rsp0_data, rsp1_valid, DATA_W'(i)); end
      total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL drain_wait%0d: got g=%b want 0", i, gnt0); end
      @(negedge clk);
    end
    req0_pop = 1'b0;
    #1;
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL drain_empty: got e=%b cnt=%0d want 1 0", empty, count); end
  endtask

  task automatic test_empty_pop;
    apply_reset();
    req1_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (gnt1 !== 1'b0 || lifo_read !== 1'b0) begin bad++; $display("FAIL empty_pop%0d: got g=%b r=%b want 0 0", k, gnt1, lifo_read); end
      @(negedge clk);
    end
    req0_push = 1'b1; req0_data = 10'h16B;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || lifo_datain !== 10'h16B) begin bad++; $display("FAIL empty_push: got g=%b%b d=%h want 10 16b", gnt0, gnt1, lifo_datain); end
    @(negedge clk);
    req0_push = 1'b0;
    #1;
    total++; if (gnt1 !== 1'b1 || lifo_read !== 1'b1 || count !== 4'd1) begin bad++; $display("FAIL empty_popgnt: got g=%b r=%b cnt=%0d want 1 1 1", gnt1, lifo_read, count); end
    @(negedge clk);
    #1;
    total++; if (rsp1_valid !== 1'b1 || rsp1_data !== 10'h16B || rsp0_valid !== 1'b0) begin bad++; $display("FAIL empty_rsp: got v1=%b d=%h v0=%b want 1 16b 0", rsp1_valid, rsp1_data, rsp0_valid); end
    req1_pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention;
    logic exp0;
    apply_reset();
    req0_push = 1'b1; req0_data = 10'h0A0;
    req1_push = 1'b1; req1_data = 10'h0B0;
    for (int k = 0; k < DEPTH; k++) begin
`ifdef LIFO_ARB_FIXED_PRI_EN
      exp0 = 1'b1;
`else
      exp0 = ((k % 2) == 0);
`endif
      #1;
      total++; if (gnt0 !== exp0 || gnt1 !== !exp0 || lifo_datain !== (exp0 ? 10'h0A0 : 10'h0B0)) begin bad++; $display("FAIL contend%0d: got g=%b%b d=%h want %b%b", k, gnt0, gnt1, lifo_datain, exp0, !exp0); end
      @(negedge clk);
    end
    #1;
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL contend_full: got g=%b%b f=%b cnt=%0d want 00 1 8", gnt0, gnt1, full, count); end
    clear_reqs();
  endtask

  task automatic test_mixed;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req0_push = 1'b1; req0_data = 10'h031 + DATA_W'(i);
      @(negedge clk);
    end
    req0_data = 10'h03A; req1_pop = 1'b1;
    #1;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL mixed_cnt3: got %0d want 3", count); end
`ifdef LIFO_ARB_FIXED_PRI_EN
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || lifo_write !== 1'b1 || lifo_datain !== 10'h03A) begin bad++; $display("FAIL mixed_fixed_push: got g=%b%b w=%b d=%h want 10 1 03a", gnt0, gnt1, lifo_write, lifo_datain); end
    @(negedge clk);
    req0_push = 1'b0;
    #1;
    total++; if (count !== 4'd4 || gnt1 !== 1'b1 || lifo_read !== 1'b1) begin bad++; $display("FAIL mixed_fixed_pop: got cnt=%0d g1=%b r=%b want 4 1 1", count, gnt1, lifo_read); end
    @(negedge clk);
    #1;
    total++; if (count !== 4'd3 || rsp1_valid !== 1'b1 || rsp1_data !== 10'h03A) begin bad++; $display("FAIL mixed_fixed_rsp: got cnt=%0d v=%b d=%h want 3 1 03a", count, rsp1_valid, rsp1_data); end
    req1_pop = 1'b0;
`else
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || lifo_read !== 1'b1 || lifo_write !== 1'b0) begin bad++; $display("FAIL mixed_pop: got g=%b%b r=%b w=%b want 01 1 0", gnt0, gnt1, lifo_read, lifo_write); end
    @(negedge clk);
    #1;
    total++; if (count !== 4'd2 || gnt0 !== 1'b0) begin bad++; $display("FAIL mixed_wait: got cnt=%0d g0=%b want 2 0", count, gnt0); end
    total++; if (rsp1_valid !== 1'b1 || rsp1_data !== 10'h033 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL mixed_rsp: got v1=%b d=%h v0=%b want 1 033 0", rsp1_valid, rsp1_data, rsp0_valid); end
    req1_pop = 1'b0;
    @(negedge clk);
    #1;
    total++; if (gnt0 !== 1'b1 || lifo_write !== 1'b1 || lifo_datain !== 10'h03A) begin bad++; $display("FAIL mixed_push: got g=%b w=%b d=%h want 1 1 03a", gnt0, lifo_write, lifo_datain); end
    @(negedge clk);
    req0_push = 1'b0;
    #1;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL mixed_cnt_end: got %0d want 3", count); end
`endif
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_push_pop;
    apply_reset();
    req1_push = 1'b1; req1_data = 10'h021;
    @(negedge clk);
    req1_data = 10'h022;
    @(negedge clk);
    req1_push = 1'b0;
    req0_push = 1'b1; req0_pop = 1'b1; req0_data = 10'h0FF;
    #1;
    total++; if (count !== 4'd2 || gnt0 !== 1'b1 || lifo_read !== 1'b1 || lifo_write !== 1'b0) begin bad++; $display("FAIL pushpop_cmd: got cnt=%0d g=%b r=%b w=%b want 2 1 1 0", count, gnt0, lifo_read, lifo_write); end
    @(negedge clk);
    req0_push = 1'b0; req0_pop = 1'b0;
    #1;
    total++; if (count !== 4'd1 || rsp0_valid !== 1'b1 || rsp0_data !== 10'h022) begin bad++; $display("FAIL pushpop_rsp: got cnt=%0d v=%b d=%h want 1 1 022", count, rsp0_valid, rsp0_data); end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    clear_reqs();
    test_reset();
    test_fill();
    test_empty_pop();
    test_contention();
    test_mixed();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
